// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN_DEF     default PC/data width
//   INSTR_W      instruction width
//   NOP_INSTR    filler for lanes that precede an unaligned fetch target
//   fetch_state_e fetch sequencer states
//   bundle_entry_t FIFO entry layout for the default two-wide configuration
package fetch_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned ISSUE_W_DEF = 2;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD
  } fetch_state_e;

  // Entry layout of the default configuration; the top builds the same shape
  // sized by its own ISSUE_W/XLEN parameters.
  typedef struct packed {
    logic [ISSUE_W_DEF*INSTR_W-1:0] instrs;
    logic [ISSUE_W_DEF-1:0]         lane_mask;
    logic [XLEN_DEF-1:0]            pc;
  } bundle_entry_t;

  // Keep the fetched instruction for a live lane, otherwise substitute a NOP.
  function automatic logic [INSTR_W-1:0] nop_fill(input logic [INSTR_W-1:0] instr,
                                                  input logic               keep);
    return keep ? instr : NOP_INSTR;
  endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Synchronous FIFO with flush, used as the fetch bundle buffer.
//   clk, rst_n   clock, synchronous active-low reset
//   flush        drop all entries (wins over push/pop)
//   push, wdata  write request and data (ignored when full)
//   pop, rdata   read request (ignored when empty) and head data
//   count        registered occupancy
//   full, empty  occupancy flags
module bundle_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_bundle_unit.sv
// Instruction-fetch front end: reads ISSUE_W-wide bundles from a synchronous
// instruction memory, buffers them, and hands them to decode.
//   clk, rst_n                clock, synchronous active-low reset
//   imem_en, imem_addr        memory read strobe and bundle index
//   imem_rdata                bundle data, one cycle after imem_en, lane 0 in MSBs
//   redirect_valid/pc         branch/jump redirect from execute
//   out_valid/ready           bundle handshake towards decode
//   out_bundle                instructions (masked lanes hold NOPs)
//   out_lane_valid            per-lane valid, bit i = lane i
//   out_pc                    byte address of lane 0
//   stall_cnt, redirect_cnt   saturating event counters
module fetch_bundle_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     ISSUE_W    = 2,
  parameter int unsigned     IMEM_AW    = 11,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_en,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [ISSUE_W*INSTR_W-1:0] imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISSUE_W*INSTR_W-1:0] out_bundle,
  output logic [ISSUE_W-1:0]         out_lane_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                redirect_cnt
);

  localparam int unsigned     BUNDLE_W     = ISSUE_W * INSTR_W;
  localparam int unsigned     BUNDLE_BYTES = ISSUE_W * 4;
  localparam int unsigned     BB           = $clog2(BUNDLE_BYTES);
  localparam int unsigned     CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam logic [XLEN-1:0] BASE_MASK    = ~XLEN'(BUNDLE_BYTES - 1);
  localparam logic [XLEN-1:0] LANE_SEL     = XLEN'(ISSUE_W - 1);

  typedef struct packed {
    logic [BUNDLE_W-1:0] instrs;
    logic [ISSUE_W-1:0]  lane_mask;
    logic [XLEN-1:0]     pc;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            first_q, first_d;
  logic            epoch_q, epoch_d;

  // Read issued last cycle; its data is on imem_rdata this cycle.
  logic               rsp_valid_q;
  logic               rsp_epoch_q;
  logic [XLEN-1:0]    rsp_pc_q;
  logic [ISSUE_W-1:0] rsp_mask_q;

  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    fetch_base;
  logic [XLEN-1:0]    lane_off;
  logic [ISSUE_W-1:0] issue_mask;
  logic               issue;
  logic               credit;
  logic [CNT_W:0]     occupancy;

  entry_t           wr_entry;
  entry_t           rd_entry;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             unused_fifo_full;

  // A redirect takes the read port in its own cycle, bypassing the pc register.
  always_comb begin
    fetch_pc   = redirect_valid ? redirect_pc : pc_q;
    fetch_base = fetch_pc & BASE_MASK;
    lane_off   = (fetch_pc >> 2) & LANE_SEL;
  end

  // Credit counts the in-flight read but not a same-cycle pop, so a push
  // always finds room.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rsp_valid_q);
  assign credit    = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (credit) issue = 1'b1;
        else        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (credit) state_d = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
    // The FIFO is flushed by the redirect, so credit does not gate this read.
    if (redirect_valid) begin
      issue   = 1'b1;
      state_d = S_FETCH;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    first_d = first_q;
    epoch_d = epoch_q ^ redirect_valid;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      issue_mask[i] = (XLEN'(i) >= lane_off);
    end
    // Only the first bundle after reset or redirect can start mid-bundle.
    if (!(redirect_valid || first_q)) issue_mask = '1;
    if (issue) begin
      pc_d    = fetch_base + XLEN'(BUNDLE_BYTES);
      first_d = 1'b0;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[BB +: IMEM_AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      first_q     <= 1'b1;
      epoch_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_epoch_q <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      first_q     <= first_d;
      epoch_q     <= epoch_d;
      rsp_valid_q <= issue;
      rsp_epoch_q <= epoch_d;
      rsp_pc_q    <= fetch_base;
      rsp_mask_q  <= issue_mask;
    end
  end

  // A response belongs to the current epoch only if no redirect has landed
  // since it was issued; a redirect this cycle flushes it anyway.
  assign push = rsp_valid_q & (rsp_epoch_q == epoch_q) & ~redirect_valid;

  always_comb begin
    wr_entry.pc        = rsp_pc_q;
    wr_entry.lane_mask = rsp_mask_q;
    wr_entry.instrs    = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      wr_entry.instrs[(ISSUE_W-1-i)*INSTR_W +: INSTR_W] =
          nop_fill(imem_rdata[(ISSUE_W-1-i)*INSTR_W +: INSTR_W], rsp_mask_q[i]);
    end
  end

  bundle_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .wdata(wr_entry),
    .rdata(rd_entry),
    .count(fifo_count),
    .full (unused_fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid      = ~fifo_empty & ~redirect_valid;
  assign pop            = out_valid & out_ready;
  assign out_bundle     = rd_entry.instrs;
  assign out_pc         = rd_entry.pc;
  assign out_lane_valid = out_valid ? rd_entry.lane_mask : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_valid && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
